// File: rtl/dct_pkg.sv
// Constants shared by both ends of the DCT byte path, so that the serializer
// and the collector agree on block size and index width.
package dct_pkg;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } s2p_state_t;

endpackage : dct_pkg

// File: rtl/mux_s2p.sv
// Serial-to-parallel collector: gathers 8 handshaked bytes into one block and
// presents it on 8 registered lanes until the downstream stage accepts it.
module mux_s2p
   import dct_pkg::*;
#(
   parameter int WIDTH = dct_pkg::WIDTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             STBi,
   input  logic             SOFi,
   input  logic [WIDTH-1:0] DATi,
   output logic             ACKi,
   output logic             STBo,
   output logic [WIDTH-1:0] DATo0,
   output logic [WIDTH-1:0] DATo1,
   output logic [WIDTH-1:0] DATo2,
   output logic [WIDTH-1:0] DATo3,
   output logic [WIDTH-1:0] DATo4,
   output logic [WIDTH-1:0] DATo5,
   output logic [WIDTH-1:0] DATo6,
   output logic [WIDTH-1:0] DATo7,
   input  logic             ACKo,
   output logic             ERRo
);

   s2p_state_t       state;
   s2p_state_t       state_d;
   logic [IDX_W-1:0] index;
   logic [IDX_W-1:0] slot;
   logic             accept;
   logic             err;
   logic [WIDTH-1:0] lane [DEPTH];

   // SOFi forces the incoming byte into lane 0 regardless of the running count.
   always_comb begin
      state_d = state;
      accept  = 1'b0;
      slot    = SOFi ? '0 : index;
      case (state)
         COLLECT: begin
            if (STBi) begin
               accept = 1'b1;
               if (slot == IDX_W'(DEPTH - 1)) state_d = FULL;
            end
         end
         FULL: begin
            if (ACKo) state_d = COLLECT;
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= COLLECT;
         index <= '0;
         err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) lane[i] <= '0;
      end else begin
         state <= state_d;
         // A start marker arriving mid-block abandons the partial block.
         err   <= accept && SOFi && (index != '0);
         if (accept) index <= slot + IDX_W'(1);
         for (int i = 0; i < DEPTH; i++) begin
            if (accept && (slot == IDX_W'(i))) lane[i] <= DATi;
         end
      end
   end

   assign STBo  = (state == FULL);
   assign ACKi  = (state == COLLECT);
   assign ERRo  = err;
   assign DATo0 = lane[0];
   assign DATo1 = lane[1];
   assign DATo2 = lane[2];
   assign DATo3 = lane[3];
   assign DATo4 = lane[4];
   assign DATo5 = lane[5];
   assign DATo6 = lane[6];
   assign DATo7 = lane[7];

endmodule : mux_s2p

// File: tb/tb_mux_s2p.sv
// Bench for mux_s2p: directed byte streams with a block scoreboard; a monitor
// compares each presented block and counts error pulses and STBo spacing.
module tb_mux_s2p;

   logic       clk = 1'b0;
   logic       RST, STBi, SOFi, ACKo;
   logic [7:0] DATi;
   logic       ACKi, STBo, ERRo;
   logic [7:0] DATo0, DATo1, DATo2, DATo3, DATo4, DATo5, DATo6, DATo7;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int err_seen = 0;
   int err_exp = 0;
   int rise_cyc[$];
   logic [63:0] exp_q[$];
   logic stbo_prev = 1'b0;

   mux_s2p #(.WIDTH(8)) dut (
      .CLK(clk), .RST(RST), .STBi(STBi), .SOFi(SOFi), .DATi(DATi), .ACKi(ACKi),
      .STBo(STBo), .DATo0(DATo0), .DATo1(DATo1), .DATo2(DATo2), .DATo3(DATo3),
      .DATo4(DATo4), .DATo5(DATo5), .DATo6(DATo6), .DATo7(DATo7),
      .ACKo(ACKo), .ERRo(ERRo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pop the expected block whenever a new block is presented.
   always @(negedge clk) begin
      if (ERRo === 1'b1) err_seen++;
      if (RST === 1'b0 && STBo === 1'b1 && !stbo_prev) begin
         rise_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("unexpected_block", 64'd1, 64'd0);
         end else begin
            chk("block", {DATo7, DATo6, DATo5, DATo4, DATo3, DATo2, DATo1, DATo0},
                exp_q.pop_front());
         end
      end
      stbo_prev = STBo;
   end

   function automatic logic [63:0] mk_blk(input logic [7:0] base);
      logic [63:0] b;
      for (int i = 0; i < 8; i++) b[8*i +: 8] = base + 8'(i);
      return b;
   endfunction

   task automatic send(input logic [7:0] d, input logic sof);
      int t;
      STBi = 1'b1; SOFi = sof; DATi = d;
      t = 0;
      @(negedge clk);
      while (ACKi !== 1'b1 && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (t >= 50) chk("send_timeout", 64'd1, 64'd0);
      @(posedge clk); #1;
      STBi = 1'b0; SOFi = 1'b0;
   endtask

   task automatic send_blk(input logic [7:0] base, input logic first_sof, input bit gap);
      for (int i = 0; i < 8; i++) begin
         send(base + 8'(i), (i == 0) ? first_sof : 1'b0);
         if (gap && i < 7) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic consume();
      int t = 0;
      while (STBo !== 1'b1 && t < 50) begin
         t++;
         @(posedge clk); #1;
      end
      if (t >= 50) chk("consume_timeout", 64'd1, 64'd0);
      ACKo = 1'b1;
      @(posedge clk); #1;
      ACKo = 1'b0;
   endtask

   initial begin
      int e0;
      RST = 1'b1; STBi = 1'b0; SOFi = 1'b0; DATi = 8'h00; ACKo = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stbo", 64'(STBo), 64'd0);
      chk("rst_acki", 64'(ACKi), 64'd1);
      chk("rst_erro", 64'(ERRo), 64'd0);
      chk("rst_dato0", 64'(DATo0), 64'd0);
      @(posedge clk); #1;
      RST = 1'b0;

      // 1: contiguous block with SOF on first byte
      exp_q.push_back(mk_blk(8'h10));
      send_blk(8'h10, 1'b1, 1'b0);
      chk("t1_stbo", 64'(STBo), 64'd1);
      chk("t1_acki", 64'(ACKi), 64'd0);

      // 2: hold off downstream while upstream keeps offering 0xFF
      STBi = 1'b1; DATi = 8'hFF;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_hold", {ACKi, STBo, DATo0, DATo7}, {1'b0, 1'b1, 8'h10, 8'h17});
      end
      STBi = 1'b0;
      ACKo = 1'b1;
      @(posedge clk); #1;
      ACKo = 1'b0;
      chk("t2_release", {STBo, ACKi}, {1'b0, 1'b1});
      exp_q.push_back(mk_blk(8'h30));
      send_blk(8'h30, 1'b0, 1'b0);
      consume();

      // 3: SOF resync after a 3-byte partial block
      e0 = err_seen;
      send(8'hA0, 1'b1); send(8'hA1, 1'b0); send(8'hA2, 1'b0);
      exp_q.push_back(mk_blk(8'h55));
      err_exp++;
      send_blk(8'h55, 1'b1, 1'b0);
      chk("t3_err_pulses", 64'(err_seen - e0), 64'd1);
      consume();

      // 4: gapped input
      exp_q.push_back(mk_blk(8'h01));
      for (int i = 0; i < 8; i++) begin
         send(8'h01 + 8'(i), i == 0);
         if (i == 6) chk("t4_early_stbo", 64'(STBo), 64'd0);
         if (i < 7) begin
            @(posedge clk); #1;
         end
      end
      chk("t4_stbo", 64'(STBo), 64'd1);
      consume();

      // 5: reset mid-block
      send_blk(8'h90, 1'b1, 1'b0);
      exp_q.push_back(mk_blk(8'h90));
      consume();
      e0 = err_seen;
      for (int i = 0; i < 5; i++) send(8'h90 + 8'(i), i == 0);
      RST = 1'b1;
      @(posedge clk); #1;
      chk("t5_rst_stbo", {STBo, ACKi, ERRo}, {1'b0, 1'b1, 1'b0});
      @(posedge clk); #1;
      RST = 1'b0;
      exp_q.push_back(mk_blk(8'h20));
      send_blk(8'h20, 1'b0, 1'b0);
      consume();
      chk("t5_no_err", 64'(err_seen - e0), 64'd0);

      // 6: back-to-back with ACKo tied high
      repeat (2) @(posedge clk); #1;
      rise_cyc.delete();
      ACKo = 1'b1;
      exp_q.push_back(mk_blk(8'h40));
      exp_q.push_back(mk_blk(8'h50));
      send_blk(8'h40, 1'b1, 1'b0);
      send_blk(8'h50, 1'b1, 1'b0);
      repeat (3) @(posedge clk); #1;
      ACKo = 1'b0;
      chk("t6_stbo_low", 64'(STBo), 64'd0);
      if (rise_cyc.size() == 2) chk("t6_spacing", 64'(rise_cyc[1] - rise_cyc[0]), 64'd9);
      else chk("t6_rise_count", 64'(rise_cyc.size()), 64'd2);

      repeat (3) @(posedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      chk("err_total", 64'(err_seen), 64'(err_exp));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1);
   end

endmodule : tb_mux_s2p
